// File: rtl/fifo_read_unpacker.sv
// Read-side unpacker: FIFO request port to a beat stream; UNPACKER_MSB_FIRST_EN selects MSB-slice-first beat order.
// Latency: request to first beat is 2 cycles. A 2-word buffer throttles requests during downstream stalls.
module fifo_read_unpacker #(
  parameter int IN_WIDTH  = 32,
  parameter int RATIO     = 4,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [IN_WIDTH-1:0]  fifo_dout,
  input  logic                 fifo_dout_valid,
  output logic                 fifo_dout_ready,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 dout_last
);

  localparam int BEAT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);

  generate
    if ((RATIO < 1) || (IN_WIDTH != RATIO * OUT_WIDTH)) begin : g_width_check
      $error("fifo_read_unpacker: IN_WIDTH must equal RATIO*OUT_WIDTH with RATIO >= 1");
    end
  endgenerate

  logic [IN_WIDTH-1:0] word_buf [2];
  logic                head;
  logic                tail;
  logic [1:0]          occ;
  logic                req_q;
  logic                run;
  logic [BEAT_W-1:0]   beat;

  logic                push;
  logic                pop;
  logic                xfer;
  logic                beat_end;
  logic [2:0]          pending;

  assign dout_valid = (occ != 2'd0);
  assign beat_end   = (beat == LAST_BEAT);
  assign xfer       = dout_valid && dout_ready;
  assign pop        = xfer && beat_end;
  // Responses without an outstanding request are dropped, so occ cannot overflow.
  assign push       = fifo_dout_valid && req_q;
  assign dout_last  = dout_valid && beat_end;

  // Counting the same-cycle pop lets a single buffered word sustain full rate.
  assign pending         = {1'b0, occ} + {2'b00, req_q} - {2'b00, pop};
  assign fifo_dout_ready = run && (pending < 3'd2);

  always_comb begin
    dout = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (beat == BEAT_W'(k)) begin
`ifdef UNPACKER_MSB_FIRST_EN
        dout = word_buf[head][IN_WIDTH-1-k*OUT_WIDTH -: OUT_WIDTH];
`else
        dout = word_buf[head][k*OUT_WIDTH +: OUT_WIDTH];
`endif
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run         <= 1'b0;
      req_q       <= 1'b0;
      occ         <= 2'd0;
      head        <= 1'b0;
      tail        <= 1'b0;
      beat        <= '0;
      word_buf[0] <= '0;
      word_buf[1] <= '0;
    end else begin
      run   <= 1'b1;
      req_q <= fifo_dout_ready;
      occ   <= occ + {1'b0, push} - {1'b0, pop};
      if (push) begin
        word_buf[tail] <= fifo_dout;
        tail           <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      if (xfer) begin
        beat <= beat_end ? '0 : beat + 1'b1;
      end
    end
  end

endmodule
